// File: rtl/soc_sysid_checker.sv
// Reads the system ID word (and, when SYSID_CHECK_TS_EN is defined, the timestamp word)
// over Avalon-MM and compares them against expected values, with per-read timeout/retry.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic [3:0]  MAX_RETRIES    = 4'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_seen,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_ID  = 3'd1;
  localparam logic [2:0] WAIT_ID = 3'd2;
  localparam logic [2:0] FINISH  = 3'd5;
`ifdef SYSID_CHECK_TS_EN
  localparam logic [2:0] REQ_TS   = 3'd3;
  localparam logic [2:0] WAIT_TS  = 3'd4;
  localparam logic [2:0] AFTER_ID = REQ_TS;
`else
  localparam logic [2:0] AFTER_ID = FINISH;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic        gap_q, gap_d;
  logic        got_q, got_d;
  logic        id_ok_q, id_ok_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] id_seen_q, id_seen_d;
`ifdef SYSID_CHECK_TS_EN
  logic        ts_ok_q, ts_ok_d;
`endif

  logic       req_phase, wait_phase, word_ts, accept, cap, stalled, tmo_fire;
  logic [2:0] req_state;

  // Avalon-MM read handshake: read/address are the request and stay stable while
  // waitrequest is high; the read is accepted on the cycle read=1 and waitrequest=0.
  // readdatavalid qualifies readdata and is honoured only in WAIT_x or the acceptance cycle.
  always_comb begin
    req_phase  = (state_q == REQ_ID);
    wait_phase = (state_q == WAIT_ID);
    word_ts    = 1'b0;
    req_state  = REQ_ID;
`ifdef SYSID_CHECK_TS_EN
    if (state_q == REQ_TS) begin
      req_phase = 1'b1;
      word_ts   = 1'b1;
      req_state = REQ_TS;
    end
    if (state_q == WAIT_TS) begin
      wait_phase = 1'b1;
      word_ts    = 1'b1;
      req_state  = REQ_TS;
    end
`endif
    read     = req_phase && !gap_q;
    address  = word_ts;
    accept   = read && !waitrequest;
    cap      = readdatavalid && (accept || (wait_phase && !got_q));
    stalled  = (req_phase && !accept) || (wait_phase && !got_q && !readdatavalid);
    tmo_fire = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};
    busy     = (state_q != IDLE) && (state_q != FINISH);
    done     = (state_q == FINISH);
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    gap_d     = 1'b0;
    got_d     = got_q;
    id_ok_d   = id_ok_q;
    tmo_err_d = tmo_err_q;
    id_seen_d = id_seen_q;
`ifdef SYSID_CHECK_TS_EN
    ts_ok_d   = ts_ok_q;
    if (cap && word_ts) ts_ok_d = (readdata == EXPECTED_TS);
`endif
    if (cap && !word_ts) begin
      id_seen_d = readdata;
      id_ok_d   = (readdata == EXPECTED_ID);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ_ID;
          tmo_d     = 16'd0;
          retry_d   = 4'd0;
          got_d     = 1'b0;
          id_ok_d   = 1'b0;
          tmo_err_d = 1'b0;
`ifdef SYSID_CHECK_TS_EN
          ts_ok_d   = 1'b0;
`endif
        end
      end
      REQ_ID: begin
        if (accept) begin
          state_d = WAIT_ID;
          got_d   = readdatavalid;
          tmo_d   = tmo_q + 16'd1;
        end
      end
      WAIT_ID: begin
        if (got_q || readdatavalid) begin
          state_d = AFTER_ID;
          tmo_d   = 16'd0;
          retry_d = 4'd0;
          got_d   = 1'b0;
        end
      end
`ifdef SYSID_CHECK_TS_EN
      REQ_TS: begin
        if (accept) begin
          state_d = WAIT_TS;
          got_d   = readdatavalid;
          tmo_d   = tmo_q + 16'd1;
        end
      end
      WAIT_TS: begin
        if (got_q || readdatavalid) state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // No progress this cycle: count, and on expiry either retry the same word after a
    // one-cycle read gap or give up on the whole sequence.
    if (stalled) begin
      if (tmo_fire) begin
        if (retry_q < MAX_RETRIES) begin
          retry_d = retry_q + 4'd1;
          tmo_d   = 16'd0;
          gap_d   = 1'b1;
          got_d   = 1'b0;
          state_d = req_state;
        end else begin
          tmo_err_d = 1'b1;
          state_d   = FINISH;
        end
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      tmo_q     <= 16'd0;
      retry_q   <= 4'd0;
      gap_q     <= 1'b0;
      got_q     <= 1'b0;
      id_ok_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      id_seen_q <= 32'd0;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      got_q     <= got_d;
      id_ok_q   <= id_ok_d;
      tmo_err_q <= tmo_err_d;
      id_seen_q <= id_seen_d;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_q   <= ts_ok_d;
`endif
    end
  end

  assign id_ok       = id_ok_q;
  assign timeout_err = tmo_err_q;
  assign id_seen     = id_seen_q;
  assign state_dbg   = state_q;
`ifdef SYSID_CHECK_TS_EN
  assign ts_ok = ts_ok_q;
`else
  logic unused_ts;
  assign unused_ts = ^EXPECTED_TS;
  assign ts_ok = 1'b0;
`endif

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Bench for soc_sysid_checker: directed and randomized sequences against a behavioural
// Avalon-MM slave, with results predicted from the checker's intended behaviour.
module tb_soc_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'h1234_5678;
  localparam logic [31:0] EXP_TS  = 32'h0000_00AA;
  localparam int          TMO     = 10;
  localparam int          RETRIES = 2;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
  localparam int NW    = 2;
`else
  localparam bit TS_EN = 1'b0;
  localparam int NW    = 1;
`endif

  logic        clock = 1'b0;
  logic        reset, start;
  logic        address, read, waitrequest, readdatavalid;
  logic [31:0] readdata;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_seen;
  logic [2:0]  state_dbg;

  soc_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (16'(TMO)),
    .MAX_RETRIES    (4'(RETRIES))
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .busy          (busy),
    .done          (done),
    .id_ok         (id_ok),
    .ts_ok         (ts_ok),
    .timeout_err   (timeout_err),
    .id_seen       (id_seen),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // behavioural slave: stalls cfg_wait cycles per request, answers with latency 0 or 1
  int          cfg_wait = 0;
  int          cfg_lat  = 1;
  bit          cfg_resp = 1'b1;
  bit          spur     = 1'b0;
  logic [31:0] cfg_id   = 32'd0;
  logic [31:0] cfg_ts   = 32'd0;
  int          stall_left = 0;
  logic        pend = 1'b0;
  logic        pend_addr = 1'b0;
  logic        rd_addr;

  always @(posedge clock) begin
    if (reset) begin
      pend       <= 1'b0;
      stall_left <= cfg_wait;
    end else begin
      pend      <= cfg_resp && (cfg_lat == 1) && read && !waitrequest;
      pend_addr <= address;
      if (read && waitrequest) stall_left <= stall_left - 1;
      else                     stall_left <= cfg_wait;
    end
  end

  assign waitrequest   = read && (stall_left != 0);
  assign readdatavalid = spur || (cfg_resp && (((cfg_lat == 0) && read && !waitrequest) || pend));
  assign rd_addr       = (cfg_lat == 0) ? address : pend_addr;
  assign readdata      = spur ? 32'hDEAD_BEEF : (rd_addr ? cfg_ts : cfg_id);

  // bus monitor
  int   acc0, acc1, rd0_cyc, hold_err, done_cnt;
  logic prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  always @(negedge clock) begin
    if (read && !waitrequest) begin
      if (address) acc1++;
      else         acc0++;
    end
    if (read && !address) rd0_cyc++;
    if (prev_stall && !(read && (address == prev_addr))) hold_err++;
    prev_stall = read && waitrequest;
    prev_addr  = address;
    if (done) done_cnt++;
  end

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_id_seen = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full check sequence; expectations come from the intended behaviour: each word costs
  // its stall cycles plus one accept cycle plus one data cycle, and one more cycle for done.
  task automatic run_seq(input string tag, input int w, input int lat, input bit resp,
                         input logic [31:0] idw, input logic [31:0] tsw, input bit poke);
    int   cyc;
    bit   seen;
    logic busy1;
    logic e_id_ok, e_ts_ok, e_tmo;
    int   e_acc0, e_acc1, e_cyc;
    cfg_wait = w; cfg_lat = lat; cfg_resp = resp; cfg_id = idw; cfg_ts = tsw;
    acc0 = 0; acc1 = 0; rd0_cyc = 0; hold_err = 0; done_cnt = 0;
    if (resp) begin
      e_id_ok = (idw == EXP_ID);
      e_ts_ok = TS_EN && (tsw == EXP_TS);
      e_tmo   = 1'b0;
      e_acc0  = 1;
      e_acc1  = NW - 1;
      e_cyc   = 1 + NW * (w + 2);
      exp_id_seen = idw;
    end else begin
      e_id_ok = 1'b0;
      e_ts_ok = 1'b0;
      e_tmo   = 1'b1;
      e_acc0  = RETRIES + 1;
      e_acc1  = 0;
      e_cyc   = 0;
    end
    start = 1'b1;
    cyc = 0; seen = 1'b0; busy1 = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      start = poke && (cyc == 2);
      if (cyc == 1) busy1 = busy;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_after_start"}, 32'(busy1), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_id_ok"}, 32'(id_ok), 32'(e_id_ok));
    check({tag, "_ts_ok"}, 32'(ts_ok), 32'(e_ts_ok));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(e_tmo));
    check({tag, "_id_seen"}, id_seen, exp_id_seen);
    if (resp) begin
      check({tag, "_cycles"}, 32'(cyc), 32'(e_cyc));
      check({tag, "_read_cycles_a0"}, 32'(rd0_cyc), 32'(w + 1));
    end
    repeat (3) @(negedge clock);
    check({tag, "_accepts_a0"}, 32'(acc0), 32'(e_acc0));
    check({tag, "_accepts_a1"}, 32'(acc1), 32'(e_acc1));
    check({tag, "_hold_err"}, 32'(hold_err), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  int          cyc;
  logic [31:0] rid, rts;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_read", 32'(read), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_id_ok", 32'(id_ok), 32'd0);
    check("rst_ts_ok", 32'(ts_ok), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_id_seen", id_seen, 32'd0);

    run_seq("basic", 0, 1, 1'b1, EXP_ID, EXP_TS, 1'b0);
    run_seq("bad_id", 0, 1, 1'b1, 32'h1234_5679, EXP_TS, 1'b0);
    run_seq("zero_lat", 0, 0, 1'b1, EXP_ID, EXP_TS, 1'b0);
    run_seq("stall7", 7, 1, 1'b1, EXP_ID, EXP_TS, 1'b0);
    run_seq("start_busy", 1, 1, 1'b1, EXP_ID, 32'h0000_00AB, 1'b1);

    // stray readdatavalid while idle must not disturb captured results
    spur = 1'b1;
    repeat (3) @(negedge clock);
    spur = 1'b0;
    @(negedge clock);
    check("spur_id_seen", id_seen, exp_id_seen);
    check("spur_id_ok", 32'(id_ok), 32'd1);
    check("spur_busy", 32'(busy), 32'd0);

    run_seq("timeout", 0, 1, 1'b0, EXP_ID, EXP_TS, 1'b0);

    // reset while waiting for the last word's data
    cfg_wait = 0; cfg_lat = 1; cfg_resp = 1'b1; cfg_id = EXP_ID; cfg_ts = EXP_TS;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!(read && !waitrequest && (address == TS_EN)) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("midrst_reached", 32'(cyc < 50), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_id_seen = 32'd0;
    check("midrst_read", 32'(read), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_id_ok", 32'(id_ok), 32'd0);
    check("midrst_ts_ok", 32'(ts_ok), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    check("midrst_id_seen", id_seen, 32'd0);
    run_seq("after_rst", 0, 1, 1'b1, EXP_ID, EXP_TS, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_seq($sformatf("rand%0d", i), $urandom_range(0, 5), $urandom_range(0, 1),
              1'b1, rid, rts, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
